branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Consumes the 2-bit `cmp` and `zero` relation codes produced by the D-stage comparator and turns them into a branch decision.
- Decides taken / not-taken for the branch or jump in D and drives a PC-redirect handshake toward the F stage.
- Stalls D while forwarded operands are not ready, or while a redirect has not been accepted.
- Adds no latency when F accepts immediately. Holds the redirect across F back-pressure and aborts cleanly on pipeline flush.

Parameters:
- PC_W, 32, width of PC and target buses.
- LINK_OFS, 8, byte offset added to `d_pc` to form the link address (delay-slot ISA).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  exception/eret flush from M; aborts any pending branch work.
- d_valid  in  1  D stage holds a valid instruction.
- br_type  in  4  branch class, encoded in the shared package.
- operand_ready  in  1  forwarded rs/rt values are final this cycle.
- cmp  in  2  rs-vs-rt relation code (CMP_EQ/CMP_GT/CMP_LT; 2'b00 = invalid).
- zero  in  2  rs-vs-0 relation code (ZERO_EQ/ZERO_GT/ZERO_LT; 2'b00 = invalid).
- d_pc  in  PC_W  PC of the D instruction.
- br_target  in  PC_W  PC-relative/J-form target.
- rs_val  in  PC_W  register target for JR/JALR.
- redirect_valid  out  1  new PC offered to F.
- redirect_pc  out  PC_W  new PC.
- redirect_ready  in  1  F accepts the redirect this cycle.
- stall_d  out  1  freeze D (and upstream).
- link_we  out  1  JAL/JALR link write qualifier.
- link_pc  out  PC_W  d_pc + LINK_OFS.
- cmp_err  out  1  one-cycle pulse: conditional branch resolved with an invalid code.

Behaviour:
- Reset (reset low, asynchronous): state IDLE; held target cleared to 0; redirect_valid=0, stall_d=0, link_we=0, cmp_err=0.
- br_type encodings: NONE=0, BEQ=1, BNE=2, BLEZ=3, BGTZ=4, BLTZ=5, BGEZ=6, J=7, JAL=8, JR=9, JALR=10. Values 11–15 are treated as NONE.
- Taken rules:
  - BEQ: cmp==CMP_EQ. BNE: cmp is CMP_GT or CMP_LT.
  - BLEZ: zero is EQ or LT. BGTZ: zero==GT. BLTZ: zero==LT. BGEZ: zero is EQ or GT.
  - J/JAL/JR/JALR: always taken.
- Targets: JR/JALR use rs_val; all other taken types use br_target.
- States:
  - IDLE
    - Not a resolvable branch (d_valid=0 or br_type=NONE): no outputs asserted.
    - Branch with operand_ready=0, or JR/JALR with operand_ready=0: stall_d=1, go to WAIT_OPS.
    - Branch with operand_ready=1: resolve combinationally this cycle.
      - Not taken: no redirect, no stall.
      - Taken with redirect_ready=1: redirect_valid=1 in the same cycle (zero latency).
      - Taken with redirect_ready=0: latch the target, stall_d=1, go to HOLD.
  - WAIT_OPS
    - stall_d=1 while operand_ready=0.
    - When operand_ready=1, resolve exactly as in IDLE and leave for IDLE or HOLD.
  - HOLD
    - redirect_valid=1 with redirect_pc = latched target, stable until accepted; stall_d=1.
    - On redirect_ready=1: go to IDLE; stall_d=0 in that cycle.
- link_we = d_valid & (JAL|JALR) in the resolving cycle only, never while stalled. link_pc is always d_pc+LINK_OFS, mod 2^PC_W.
- Invalid code (2'b00) on the code a conditional branch uses: treated as not taken, cmp_err pulses for 1 cycle.
- flush=1 in any state: next state IDLE. Same-cycle redirect_valid, stall_d and link_we are forced to 0. flush overrides a simultaneous resolve or accept.
- Reset asserted mid-HOLD: drops to IDLE; the redirect is lost by design.

Optional Feature:
- Macro BRANCH_RESOLVER_STATS_EN.
- Defined: adds outputs stat_taken[31:0] and stat_stall[31:0], both reset to 0.
  - stat_taken increments on each accepted taken redirect.
  - stat_stall increments on each cycle stall_d=1.
  - Both wrap at 2^32.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - br_type codes;
  - CMP_EQ=2'b01, CMP_GT=2'b10, CMP_LT=2'b11;
  - ZERO_EQ=2'b01, ZERO_GT=2'b10, ZERO_LT=2'b11;
  - FSM state codes IDLE/WAIT_OPS/HOLD.
- One natural sub-module, br_cond_eval: purely combinational; inputs br_type/cmp/zero; outputs taken, is_jump_reg and code_invalid. The FSM, target latch and optional counters stay in the top module.

Test Plan:
- BEQ, cmp=CMP_EQ, operand_ready=1, redirect_ready=1, br_target=0x00003010 -> same cycle redirect_valid=1, redirect_pc=0x00003010, stall_d=0.
- BGTZ, zero=ZERO_EQ -> no redirect, stall_d=0. Then BLTZ with zero=2'b00 -> not taken, cmp_err high for exactly 1 cycle.
- JR with operand_ready low 3 cycles then high, rs_val=0x00400020 -> stall_d=1 for 3 cycles, then redirect to 0x00400020.
- JAL, d_pc=0x00003000, redirect_ready low 2 cycles -> redirect_pc held stable; link_we=1 only in first resolve cycle with link_pc=0x00003008; stall_d cleared on accept.
- flush during HOLD, and reset low mid-WAIT_OPS -> next cycle IDLE; redirect_valid=0, stall_d=0.
- BRANCH_RESOLVER_STATS_EN build: 2 taken (one with 1 hold cycle) plus one 3-cycle operand wait -> stat_taken=2, stat_stall=4.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: branch classes, relation codes and FSM states shared by the branch resolver
package branch_resolver_pkg;
  typedef enum logic [3:0] {
    BR_NONE = 4'd0, BR_BEQ = 4'd1, BR_BNE = 4'd2, BR_BLEZ = 4'd3, BR_BGTZ = 4'd4, BR_BLTZ = 4'd5,
    BR_BGEZ = 4'd6, BR_J = 4'd7, BR_JAL = 4'd8, BR_JR = 4'd9, BR_JALR = 4'd10
  } br_t;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_OPS = 2'd1, HOLD = 2'd2} state_t;
  localparam logic [1:0] CODE_INV = 2'b00;
  localparam logic [1:0] CMP_EQ = 2'b01, CMP_GT = 2'b10, CMP_LT = 2'b11;
  localparam logic [1:0] ZERO_EQ = 2'b01, ZERO_GT = 2'b10, ZERO_LT = 2'b11;
  function automatic logic is_branch(input logic [3:0] t);
    return t inside {[BR_BEQ:BR_JALR]};
  endfunction
endpackage

// File: rtl/branch_resolver_cond.sv
// br_cond_eval: combinational taken/not-taken decision from the D-stage relation codes
module br_cond_eval
  import branch_resolver_pkg::*;
(
  input  logic [3:0] br_type,
  input  logic [1:0] cmp,
  input  logic [1:0] zero,
  output logic       taken,
  output logic       is_jump_reg,
  output logic       code_invalid
);
  always_comb begin
    is_jump_reg  = br_type == BR_JR || br_type == BR_JALR;
    code_invalid = (br_type == BR_BEQ || br_type == BR_BNE) ? cmp == CODE_INV :
                   (br_type inside {[BR_BLEZ:BR_BGEZ]}) ? zero == CODE_INV : 1'b0;
    taken = br_type == BR_BEQ  ? cmp == CMP_EQ :
            br_type == BR_BNE  ? (cmp == CMP_GT || cmp == CMP_LT) :
            br_type == BR_BLEZ ? (zero == ZERO_EQ || zero == ZERO_LT) :
            br_type == BR_BGTZ ? zero == ZERO_GT :
            br_type == BR_BLTZ ? zero == ZERO_LT :
            br_type == BR_BGEZ ? (zero == ZERO_EQ || zero == ZERO_GT) :
            br_type inside {[BR_J:BR_JALR]};
  end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: D-stage branch decision and PC-redirect handshake toward F
// Optional stat_taken/stat_stall counters when BRANCH_RESOLVER_STATS_EN is defined.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int LINK_OFS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            d_valid,
  input  logic [3:0]      br_type,
  input  logic            operand_ready,
  input  logic [1:0]      cmp,
  input  logic [1:0]      zero,
  input  logic [PC_W-1:0] d_pc,
  input  logic [PC_W-1:0] br_target,
  input  logic [PC_W-1:0] rs_val,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            stall_d,
  output logic            link_we,
  output logic [PC_W-1:0] link_pc,
  output logic            cmp_err
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0]     stat_taken,
  output logic [31:0]     stat_stall
`endif
);
  state_t          state;
  logic [PC_W-1:0] hold_pc, target;
  logic            taken, is_jr, code_inv, kill, br, resolve;
  br_cond_eval u_eval (
    .br_type(br_type),
    .cmp(cmp),
    .zero(zero),
    .taken(taken),
    .is_jump_reg(is_jr),
    .code_invalid(code_inv)
  );
  // kill also covers reset so outputs read idle while reset is held
  always_comb begin
    kill           = flush || !reset;
    br             = d_valid && is_branch(br_type);
    resolve        = state != HOLD && br && operand_ready && !kill;
    target         = is_jr ? rs_val : br_target;
    redirect_valid = !kill && (state == HOLD || (resolve && taken));
    redirect_pc    = state == HOLD ? hold_pc : target;
    stall_d        = !kill && (state == HOLD ? !redirect_ready :
                               br && (!operand_ready || (taken && !redirect_ready)));
    link_we        = resolve && (br_type == BR_JAL || br_type == BR_JALR);
    cmp_err        = resolve && code_inv;
    link_pc        = d_pc + PC_W'(LINK_OFS);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      hold_pc <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else if (state == HOLD) begin
      state <= redirect_ready ? IDLE : HOLD;
    end else if (br && !operand_ready) begin
      state <= WAIT_OPS;
    end else if (resolve && taken && !redirect_ready) begin
      state   <= HOLD;
      hold_pc <= target;
    end else begin
      state <= IDLE;
    end
  end
`ifdef BRANCH_RESOLVER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_taken <= '0;
      stat_stall <= '0;
    end else begin
      stat_taken <= stat_taken + 32'(redirect_valid && redirect_ready);
      stat_stall <= stat_stall + 32'(stall_d);
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed and random checks of branch_resolver against a transaction-level model
module tb_branch_resolver;
  logic        clk = 1'b0, reset = 1'b0, flush = 1'b0, d_valid = 1'b0;
  logic        operand_ready = 1'b0, redirect_ready = 1'b0;
  logic [3:0]  br_type = 4'd0;
  logic [1:0]  cmp = 2'd0, zero = 2'd0;
  logic [31:0] d_pc = '0, br_target = '0, rs_val = '0;
  logic        redirect_valid, stall_d, link_we, cmp_err;
  logic [31:0] redirect_pc, link_pc;
  int          n_checks = 0, n_fails = 0;
  logic [31:0] held[$];
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_taken, stat_stall;
  int unsigned m_taken = 0, m_stall = 0;
`endif

  always #5 clk = ~clk;

  branch_resolver dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .d_valid(d_valid),
    .br_type(br_type),
    .operand_ready(operand_ready),
    .cmp(cmp),
    .zero(zero),
    .d_pc(d_pc),
    .br_target(br_target),
    .rs_val(rs_val),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready),
    .stall_d(stall_d),
    .link_we(link_we),
    .link_pc(link_pc),
    .cmp_err(cmp_err)
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    .stat_taken(stat_taken),
    .stat_stall(stat_stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // relation codes: 1 = equal, 2 = greater, 3 = less, 0 = unknown
  function automatic logic ref_taken(input logic [3:0] bt, input logic [1:0] c, input logic [1:0] z);
    logic rs_eq_rt, rs_ne_rt, rs_eq0, rs_gt0, rs_lt0;
    rs_eq_rt = c == 2'd1;
    rs_ne_rt = c == 2'd2 || c == 2'd3;
    rs_eq0 = z == 2'd1;
    rs_gt0 = z == 2'd2;
    rs_lt0 = z == 2'd3;
    case (bt)
      4'd1: return rs_eq_rt;
      4'd2: return rs_ne_rt;
      4'd3: return rs_eq0 || rs_lt0;
      4'd4: return rs_gt0;
      4'd5: return rs_lt0;
      4'd6: return rs_eq0 || rs_gt0;
      4'd7, 4'd8, 4'd9, 4'd10: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic cyc(input logic fl, input logic dv, input logic [3:0] bt, input logic opr,
                     input logic [1:0] c, input logic [1:0] z, input logic [31:0] pc,
                     input logic [31:0] tg, input logic [31:0] rs, input logic rr);
    logic e_rv, e_st, e_lk, e_err;
    logic [31:0] e_pc;
    e_rv = 1'b0; e_st = 1'b0; e_lk = 1'b0; e_err = 1'b0; e_pc = '0;
    flush = fl; d_valid = dv; br_type = bt; operand_ready = opr; cmp = c; zero = z;
    d_pc = pc; br_target = tg; rs_val = rs; redirect_ready = rr;
    if (held.size() != 0) begin
      e_rv = !fl;
      e_pc = held[0];
      e_st = !fl && !rr;
    end else if (dv && bt >= 4'd1 && bt <= 4'd10 && !fl) begin
      if (!opr) e_st = 1'b1;
      else begin
        e_lk = bt == 4'd8 || bt == 4'd10;
        e_err = ((bt == 4'd1 || bt == 4'd2) && c == 2'd0) || (bt >= 4'd3 && bt <= 4'd6 && z == 2'd0);
        if (ref_taken(bt, c, z)) begin
          e_rv = 1'b1;
          e_pc = (bt == 4'd9 || bt == 4'd10) ? rs : tg;
          e_st = !rr;
        end
      end
    end
    #1;
    chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
    if (e_rv) chk("redirect_pc", redirect_pc, e_pc);
    chk("stall_d", 32'(stall_d), 32'(e_st));
    chk("link_we", 32'(link_we), 32'(e_lk));
    chk("cmp_err", 32'(cmp_err), 32'(e_err));
    chk("link_pc", link_pc, pc + 32'd8);
    if (held.size() != 0) begin
      if (fl || rr) held.delete(0);
    end else if (e_rv && !rr) held.push_back(e_pc);
`ifdef BRANCH_RESOLVER_STATS_EN
    m_taken += 32'(e_rv && rr);
    m_stall += 32'(e_st);
`endif
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    held.delete();
`ifdef BRANCH_RESOLVER_STATS_EN
    m_taken = 0;
    m_stall = 0;
`endif
    #2;
    reset = 1'b1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 4'd0, 1'b1, 2'd0, 2'd0, 32'h100, 32'h0, 32'h0, 1'b1);
  endtask

  initial begin
    d_valid = 1'b1; br_type = 4'd1; operand_ready = 1'b1; cmp = 2'd1; redirect_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("reset_stall_d", 32'(stall_d), 32'd0);
    chk("reset_link_we", 32'(link_we), 32'd0);
    chk("reset_cmp_err", 32'(cmp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    // zero-latency taken BEQ
    cyc(1'b0, 1'b1, 4'd1, 1'b1, 2'd1, 2'd0, 32'h3000, 32'h3010, 32'h0, 1'b1);
    // not-taken BGTZ, then BLTZ with unknown zero code
    cyc(1'b0, 1'b1, 4'd4, 1'b1, 2'd0, 2'd1, 32'h3004, 32'h3100, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, 4'd5, 1'b1, 2'd1, 2'd0, 32'h3008, 32'h3200, 32'h0, 1'b1);
    idle();
    // JR waiting three cycles on operands
    repeat (3) cyc(1'b0, 1'b1, 4'd9, 1'b0, 2'd0, 2'd0, 32'h300c, 32'h0, 32'h00400020, 1'b1);
    cyc(1'b0, 1'b1, 4'd9, 1'b1, 2'd0, 2'd0, 32'h300c, 32'h0, 32'h00400020, 1'b1);
    // JAL held for two cycles of back-pressure
    cyc(1'b0, 1'b1, 4'd8, 1'b1, 2'd0, 2'd0, 32'h3000, 32'h5000, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'd8, 1'b1, 2'd0, 2'd0, 32'h3000, 32'h6000, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'd8, 1'b1, 2'd0, 2'd0, 32'h3000, 32'h7000, 32'h0, 1'b1);
    idle();
    // link address wraps around the PC space
    cyc(1'b0, 1'b1, 4'd10, 1'b1, 2'd0, 2'd0, 32'hFFFFFFFC, 32'h0, 32'h8000, 1'b1);
    // flush in HOLD drops the pending redirect
    cyc(1'b0, 1'b1, 4'd2, 1'b1, 2'd2, 2'd0, 32'h4000, 32'h4400, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 4'd2, 1'b1, 2'd2, 2'd0, 32'h4000, 32'h4400, 32'h0, 1'b1);
    idle();
    // reset in WAIT_OPS, then reset in HOLD
    cyc(1'b0, 1'b1, 4'd10, 1'b0, 2'd0, 2'd0, 32'h4800, 32'h0, 32'h9000, 1'b1);
    do_reset();
    idle();
    cyc(1'b0, 1'b1, 4'd7, 1'b1, 2'd0, 2'd0, 32'h4900, 32'hA000, 32'h0, 1'b0);
    do_reset();
    idle();
`ifdef BRANCH_RESOLVER_STATS_EN
    do_reset();
    cyc(1'b0, 1'b1, 4'd1, 1'b1, 2'd1, 2'd0, 32'h5000, 32'h5100, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, 4'd2, 1'b1, 2'd3, 2'd0, 32'h5004, 32'h5200, 32'h0, 1'b0);
    cyc(1'b0, 1'b1, 4'd2, 1'b1, 2'd3, 2'd0, 32'h5004, 32'h5200, 32'h0, 1'b1);
    repeat (3) cyc(1'b0, 1'b1, 4'd6, 1'b0, 2'd0, 2'd0, 32'h5008, 32'h5300, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, 4'd6, 1'b1, 2'd0, 2'd3, 32'h5008, 32'h5300, 32'h0, 1'b1);
    #1;
    chk("stat_taken_directed", stat_taken, 32'd2);
    chk("stat_stall_directed", stat_stall, 32'd4);
    @(negedge clk);
`endif
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)),
          $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          $urandom, $urandom, $urandom, $urandom_range(0, 2) != 0);
      if (i == 200) do_reset();
    end
`ifdef BRANCH_RESOLVER_STATS_EN
    #1;
    chk("stat_taken", stat_taken, 32'(m_taken));
    chk("stat_stall", stat_stall, 32'(m_stall));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
